// File: rtl/vscale_dmem_bridge.sv
// vscale_dmem_bridge
//   Data-memory bridge between the vscale DX/WB pipeline control and an
//   external valid/ready data bus. One bus transaction is run per accepted
//   DX request. Store data is lane-replicated with a byte mask. Load data is
//   aligned and extended for WB. The bridge also produces the WB stall
//   (dmem_wait) and the memory exception (dmem_badmem_e).
//
// Parameters
//   TIMEOUT_CYCLES : REQ+RESP cycles before a forced bus error (0 = off)
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   dmem_en/_wen/_size    : DX request, store flag, funct3 access size
//   dmem_addr/_wdata      : byte address, unshifted store data
//   dmem_wait             : WB stall while the transaction is outstanding
//   dmem_badmem_e         : one-cycle WB memory exception
//   load_data_WB          : aligned/extended load result
//   bus_req_*             : request channel (valid/ready, word address,
//                           write flag, byte mask, replicated data)
//   bus_resp_*            : response channel (valid, data, error)

module vscale_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e,
  output logic [31:0] load_data_WB,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_wen,
  output logic [3:0]  bus_req_wmask,
  output logic [31:0] bus_req_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_data,
  input  logic        bus_resp_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Unknown sizes, unsigned stores and misaligned H/W accesses never reach the bus.
  function automatic logic req_illegal(input logic [2:0] size, input logic wen,
                                       input logic [1:0] off);
    case (size)
      SZ_B:    req_illegal = 1'b0;
      SZ_H:    req_illegal = off[0];
      SZ_W:    req_illegal = |off;
      SZ_BU:   req_illegal = wen;
      SZ_HU:   req_illegal = wen | off[0];
      default: req_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    store_mask = 4'b0001 << off;
      SZ_H:    store_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  endfunction

  // The bus writes whole lanes, so narrow data is replicated across the word.
  function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wdata);
    case (size)
      SZ_B:    store_data = {4{wdata[7:0]}};
      SZ_H:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] data, input logic [2:0] size,
                                              input logic [1:0] off);
    logic [31:0] sh;
    sh = data >> {off, 3'b000};
    case (size)
      SZ_B:    load_format = {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_format = {{16{sh[15]}}, sh[15:0]};
      SZ_BU:   load_format = {24'd0, sh[7:0]};
      SZ_HU:   load_format = {16'd0, sh[15:0]};
      default: load_format = sh;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               wen_q, wen_d;
  logic [2:0]         size_q, size_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        load_q, load_d;

  logic               in_req_s;
  logic               in_resp_s;
  logic               waiting_s;
  logic               resp_done_s;
  logic               timeout_s;
  logic               accept_s;
  logic               bad_req_s;
  logic               start_s;
  logic               load_done_s;
  logic [31:0]        load_fmt_s;

  // Next-state, datapath capture and handshake outputs.
  always_comb begin
    in_req_s    = (state_q == ST_REQ);
    in_resp_s   = (state_q == ST_RESP);
    resp_done_s = in_resp_s && bus_resp_valid;
    waiting_s   = in_req_s || (in_resp_s && !bus_resp_valid);
    // Only a still-pending transaction can time out; a response arriving in
    // the same cycle completes normally.
    timeout_s   = (TIMEOUT_CYCLES != 0) && waiting_s &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    // New work is taken from IDLE or a clean completion; an error/timeout
    // cycle raises badmem_e, so the request is dropped there.
    accept_s    = dmem_en && ((state_q == ST_IDLE) || (resp_done_s && !bus_resp_err));
    bad_req_s   = req_illegal(dmem_size, dmem_wen, dmem_addr[1:0]);
    start_s     = accept_s && !bad_req_s;

    load_fmt_s  = load_format(bus_resp_data, size_q, off_q);
    load_done_s = resp_done_s && !bus_resp_err && !wen_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = bad_req_s ? ST_ERR : ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (timeout_s) begin
          state_d = ST_IDLE;
        end else if (bus_req_ready) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        if (timeout_s) begin
          state_d = ST_IDLE;
        end else if (bus_resp_valid) begin
          if (accept_s) begin
            state_d = bad_req_s ? ST_ERR : ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (start_s) begin
      cnt_d = '0;
    end else if (in_req_s || in_resp_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (start_s) begin
      addr_d  = {dmem_addr[31:2], 2'b00};
      wen_d   = dmem_wen;
      size_d  = dmem_size;
      off_d   = dmem_addr[1:0];
      wdata_d = store_data(dmem_size, dmem_wdata);
      wmask_d = dmem_wen ? store_mask(dmem_size, dmem_addr[1:0]) : 4'b0000;
    end else begin
      addr_d  = addr_q;
      wen_d   = wen_q;
      size_d  = size_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
    end

    if (load_done_s) begin
      load_d = load_fmt_s;
    end else begin
      load_d = load_q;
    end
  end

  // State, timeout counter, latched request and last load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'd0;
      wen_q   <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      load_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      load_q  <= load_d;
    end
  end

  assign bus_req_valid = in_req_s && !timeout_s;
  assign bus_req_addr  = addr_q;
  assign bus_req_wen   = wen_q;
  assign bus_req_wmask = wmask_q;
  assign bus_req_wdata = wdata_q;
  assign dmem_wait     = waiting_s && !timeout_s;
  assign dmem_badmem_e = (state_q == ST_ERR) || (resp_done_s && bus_resp_err) || timeout_s;
  // The completing load is forwarded the same cycle; otherwise hold the last one.
  assign load_data_WB  = load_done_s ? load_fmt_s : load_q;

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// tb_vscale_dmem_bridge
//   Self-checking bench for vscale_dmem_bridge (TIMEOUT_CYCLES = 4).
//   Directed scenarios for the notable cases, then randomized requests
//   with random bus latencies, checked against a byte-level model.

module tb_vscale_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;
  logic [31:0] load_data_WB;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_wen;
  logic [3:0]  bus_req_wmask;
  logic [31:0] bus_req_wdata;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_data;
  logic        bus_resp_err;

  vscale_dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .dmem_en        (dmem_en),
    .dmem_wen       (dmem_wen),
    .dmem_size      (dmem_size),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wait      (dmem_wait),
    .dmem_badmem_e  (dmem_badmem_e),
    .load_data_WB   (load_data_WB),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_req_addr   (bus_req_addr),
    .bus_req_wen    (bus_req_wen),
    .bus_req_wmask  (bus_req_wmask),
    .bus_req_wdata  (bus_req_wdata),
    .bus_resp_valid (bus_resp_valid),
    .bus_resp_data  (bus_resp_data),
    .bus_resp_err   (bus_resp_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_ld;
  logic [2:0]  nx_size;
  logic        nx_wen;
  logic [31:0] nx_addr;
  logic [31:0] nx_wdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [2:0] sz, input logic we, input logic [31:0] ad);
    int n;
    n = nbytes(sz);
    if (n == 0) return 1'b0;
    if (sz[2] && we) return 1'b0;
    return (int'(ad[1:0]) % n) == 0;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [2:0] sz, input logic we, input logic [1:0] off);
    int n;
    n = nbytes(sz);
    if (!we) return 4'b0000;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(sz);
    r = 32'd0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = 8'(wd >> (8 * (b % n)));
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [2:0] sz, input logic [1:0] off);
    int n;
    logic [63:0] lim;
    logic [63:0] v;
    n   = nbytes(sz);
    lim = 64'd1 << (8 * n);
    v   = ({32'd0, rd} >> (8 * int'(off))) % lim;
    if (!sz[2] && v >= (lim >> 1)) v = v - lim;
    return v[31:0];
  endfunction

  // ---------------- drive helpers ----------------
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] sz, input logic we, input logic [31:0] ad, input logic [31:0] wd);
    dmem_en    = 1'b1;
    dmem_size  = sz;
    dmem_wen   = we;
    dmem_addr  = ad;
    dmem_wdata = wd;
  endtask

  task automatic gen_req(output logic [2:0] sz, output logic we, output logic [31:0] ad, output logic [31:0] wd);
    int pick;
    int n;
    pick = $urandom_range(0, 19);
    case (pick % 5)
      0: sz = 3'd0;
      1: sz = 3'd1;
      2: sz = 3'd2;
      3: sz = 3'd4;
      default: sz = 3'd5;
    endcase
    if (pick == 19) sz = 3'd3 + 3'($urandom_range(0, 1)) * 3'd3;
    if (pick == 18) sz = 3'd7;
    we = 1'($urandom_range(0, 1));
    if (sz[2] && we && $urandom_range(0, 3) != 0) we = 1'b0;
    n = nbytes(sz);
    ad = {16'd0, 16'($urandom)} & 32'hFFFF_FFFC;
    if (n != 0 && $urandom_range(0, 6) != 0)
      ad = ad | 32'(n * $urandom_range(0, (4 / n) - 1));
    else
      ad = ad | 32'($urandom_range(0, 3));
    wd = $urandom;
  endtask

  // One request from its DX cycle (skipped when chained) to completion.
  task automatic run_txn(input logic [2:0] sz, input logic we, input logic [31:0] ad, input logic [31:0] wd,
                         input int rd, input int lat, input logic [31:0] rdata, input logic er,
                         input bit spurious, input bit chained_in, input bit want_chain,
                         output bit chained_out);
    bit legal;
    legal = is_legal(sz, we, ad);
    chained_out = 1'b0;
    if (!chained_in) begin
      drive_req(sz, we, ad, wd);
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
      sample();
      check_val("dx_valid",  32'(bus_req_valid), 32'd0);
      check_val("dx_wait",   32'(dmem_wait),     32'd0);
      check_val("dx_badmem", 32'(dmem_badmem_e), 32'd0);
      check_val("dx_ld",     load_data_WB,       exp_ld);
      advance();
    end
    dmem_en = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
    if (!legal) begin
      drive_req(3'd2, 1'b0, 32'h40, 32'd0);   // must be ignored in the error cycle
      sample();
      check_val("err_valid",  32'(bus_req_valid), 32'd0);
      check_val("err_wait",   32'(dmem_wait),     32'd0);
      check_val("err_badmem", 32'(dmem_badmem_e), 32'd1);
      advance();
      dmem_en = 1'b0;
      sample();
      check_val("post_err_valid",  32'(bus_req_valid), 32'd0);
      check_val("post_err_badmem", 32'(dmem_badmem_e), 32'd0);
      check_val("post_err_wait",   32'(dmem_wait),     32'd0);
      advance();
      return;
    end
    for (int k = 0; k <= rd; k++) begin
      bus_req_ready  = (k == rd);
      bus_resp_valid = (k == rd) && spurious;
      bus_resp_data  = $urandom;
      bus_resp_err   = 1'($urandom_range(0, 1));
      sample();
      check_val("req_valid",  32'(bus_req_valid), 32'd1);
      check_val("req_wait",   32'(dmem_wait),     32'd1);
      check_val("req_badmem", 32'(dmem_badmem_e), 32'd0);
      check_val("req_addr",   bus_req_addr,       {ad[31:2], 2'b00});
      check_val("req_wen",    32'(bus_req_wen),   32'(we));
      check_val("req_mask",   32'(bus_req_wmask), 32'(exp_mask(sz, we, ad[1:0])));
      if (we) check_val("req_wdata", bus_req_wdata, exp_wdata(sz, wd));
      check_val("req_ld",     load_data_WB,       exp_ld);
      advance();
    end
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
    for (int k = 1; k < lat; k++) begin
      sample();
      check_val("resp_wait",   32'(dmem_wait),     32'd1);
      check_val("resp_valid",  32'(bus_req_valid), 32'd0);
      check_val("resp_badmem", 32'(dmem_badmem_e), 32'd0);
      advance();
    end
    bus_resp_valid = 1'b1; bus_resp_data = rdata; bus_resp_err = er;
    if (want_chain) drive_req(nx_size, nx_wen, nx_addr, nx_wdata);
    if (!we && !er) exp_ld = exp_load(rdata, sz, ad[1:0]);
    sample();
    check_val("done_wait",   32'(dmem_wait),     32'd0);
    check_val("done_badmem", 32'(dmem_badmem_e), 32'(er));
    check_val("done_ld",     load_data_WB,       exp_ld);
    check_val("done_valid",  32'(bus_req_valid), 32'd0);
    advance();
    bus_resp_valid = 1'b0; bus_resp_err = 1'b0; dmem_en = 1'b0;
    chained_out = want_chain && !er;
    if (want_chain && er) begin
      sample();
      check_val("ign_valid",  32'(bus_req_valid), 32'd0);
      check_val("ign_wait",   32'(dmem_wait),     32'd0);
      check_val("ign_badmem", 32'(dmem_badmem_e), 32'd0);
      advance();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ch;
    logic [2:0]  sz;
    logic        we;
    logic [31:0] ad;
    logic [31:0] wd;
    bit          want;

    reset = 1'b1; dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0;
    dmem_addr = 32'd0; dmem_wdata = 32'd0; bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0; bus_resp_data = 32'd0; bus_resp_err = 1'b0;
    exp_ld = 32'd0;
    nx_size = 3'd2; nx_wen = 1'b0; nx_addr = 32'h300; nx_wdata = 32'd0;
    repeat (3) advance();
    reset = 1'b0;
    sample();
    check_val("rst_valid",  32'(bus_req_valid), 32'd0);
    check_val("rst_wait",   32'(dmem_wait),     32'd0);
    check_val("rst_badmem", 32'(dmem_badmem_e), 32'd0);
    check_val("rst_ld",     load_data_WB,       32'd0);
    advance();

    // Directed cases
    run_txn(3'd2, 1'b0, 32'h100, 32'd0,        0, 1, 32'hDEADBEEF, 1'b0, 0, 0, 0, ch);
    run_txn(3'd0, 1'b0, 32'h103, 32'd0,        0, 1, 32'h80FF0000, 1'b0, 0, 0, 0, ch);
    check_val("lb_val", exp_ld, 32'hFFFFFF80);
    run_txn(3'd4, 1'b0, 32'h103, 32'd0,        0, 1, 32'h80FF0000, 1'b0, 0, 0, 0, ch);
    run_txn(3'd1, 1'b1, 32'h102, 32'h1234ABCD, 0, 1, 32'h0,        1'b0, 0, 0, 0, ch);
    run_txn(3'd2, 1'b0, 32'h101, 32'd0,        0, 1, 32'h0,        1'b0, 0, 0, 0, ch);
    run_txn(3'd2, 1'b0, 32'h200, 32'd0,        3, 1, 32'h55AA55AA, 1'b1, 0, 0, 1, ch);

    // Timeout in RESP, then a late response while idle
    drive_req(3'd2, 1'b0, 32'h400, 32'd0); sample(); advance(); dmem_en = 1'b0;
    bus_req_ready = 1'b1;
    sample();
    check_val("to_valid", 32'(bus_req_valid), 32'd1);
    check_val("to_wait",  32'(dmem_wait),     32'd1);
    advance(); bus_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check_val("to_resp_wait",   32'(dmem_wait),     32'd1);
      check_val("to_resp_badmem", 32'(dmem_badmem_e), 32'd0);
      advance();
    end
    sample();
    check_val("to_fire_badmem", 32'(dmem_badmem_e), 32'd1);
    check_val("to_fire_wait",   32'(dmem_wait),     32'd0);
    check_val("to_fire_valid",  32'(bus_req_valid), 32'd0);
    advance();
    bus_resp_valid = 1'b1; bus_resp_data = 32'h12345678; bus_resp_err = 1'b1;
    sample();
    check_val("late_wait",   32'(dmem_wait),     32'd0);
    check_val("late_badmem", 32'(dmem_badmem_e), 32'd0);
    check_val("late_ld",     load_data_WB,       exp_ld);
    advance(); bus_resp_valid = 1'b0; bus_resp_err = 1'b0;

    // Timeout while the request is never accepted
    drive_req(3'd2, 1'b1, 32'h480, 32'h1); sample(); advance(); dmem_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      check_val("to_req_valid", 32'(bus_req_valid), 32'd1);
      advance();
    end
    sample();
    check_val("to_req_badmem", 32'(dmem_badmem_e), 32'd1);
    check_val("to_req_valid_drop", 32'(bus_req_valid), 32'd0);
    advance();
    sample();
    check_val("to_req_idle", 32'(bus_req_valid), 32'd0);
    advance();

    // Reset asserted while in RESP
    drive_req(3'd2, 1'b0, 32'h500, 32'd0); sample(); advance(); dmem_en = 1'b0;
    bus_req_ready = 1'b1; sample(); advance(); bus_req_ready = 1'b0;
    reset = 1'b1;
    sample();
    check_val("rr_wait_before", 32'(dmem_wait), 32'd1);
    advance();
    reset = 1'b0; exp_ld = 32'd0;
    bus_resp_valid = 1'b1; bus_resp_data = 32'hCAFEF00D; bus_resp_err = 1'b0;
    sample();
    check_val("rr_valid",  32'(bus_req_valid), 32'd0);
    check_val("rr_wait",   32'(dmem_wait),     32'd0);
    check_val("rr_badmem", 32'(dmem_badmem_e), 32'd0);
    check_val("rr_ld",     load_data_WB,       32'd0);
    advance(); bus_resp_valid = 1'b0;

    // Randomized requests, latencies, errors and back-to-back chaining
    ch = 1'b0;
    gen_req(sz, we, ad, wd);
    for (int i = 0; i < 300; i++) begin
      want = (i < 299) && ($urandom_range(0, 2) == 0);
      if (want) gen_req(nx_size, nx_wen, nx_addr, nx_wdata);
      run_txn(sz, we, ad, wd, $urandom_range(0, 1), $urandom_range(1, 2), $urandom,
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ch, want, ch);
      if (ch) begin
        sz = nx_size; we = nx_wen; ad = nx_addr; wd = nx_wdata;
      end else begin
        gen_req(sz, we, ad, wd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vscale_dmem_bridge.md
# vscale_dmem_bridge

Data-memory bridge between the vscale DX/WB pipeline control and the external data bus. It samples load/store requests issued in DX and runs one bus transaction per request with valid/ready request and valid response handshakes. It formats store lanes and byte masks, aligns and extends load data for WB, and produces the `dmem_wait` stall and `dmem_badmem_e` exception inputs consumed by pipeline control.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum wait cycles in REQ+RESP before a forced bus error; 0 disables the timeout.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `dmem_en`  in  1  DX load/store request, already gated by kill_DX
- `dmem_wen`  in  1  request is a store
- `dmem_size`  in  3  funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
- `dmem_addr`  in  32  byte address from the ALU
- `dmem_wdata`  in  32  store data (rs2, unshifted)
- `dmem_wait`  out  1  WB stall; transaction not yet complete
- `dmem_badmem_e`  out  1  one-cycle WB memory exception
- `load_data_WB`  out  32  aligned, extended load result
- `bus_req_valid`  out  1  request valid
- `bus_req_ready`  in  1  bus accepts the request
- `bus_req_addr`  out  32  word address, bits [1:0] = 0
- `bus_req_wen`  out  1  write request
- `bus_req_wmask`  out  4  byte-lane write mask
- `bus_req_wdata`  out  32  lane-replicated store data
- `bus_resp_valid`  in  1  response valid, one cycle per request
- `bus_resp_data`  in  32  read data (word)
- `bus_resp_err`  in  1  bus error, qualified by bus_resp_valid

## Operation
- States: IDLE, REQ, RESP, ERR.
- Accept: sample `dmem_en` only in IDLE or in a RESP completion cycle without error. Ignore it in every other cycle, including any cycle where `dmem_badmem_e` = 1.
- Legality: size 3/6/7 is illegal; BU/HU with `wen` is illegal; H with `addr[0]`=1 is misaligned; W with `addr[1:0]`≠0 is misaligned.
  - Illegal or misaligned: enter ERR; no bus request.
  - Otherwise: latch addr, wen, size, offset and formatted wdata/mask, then enter REQ.
- REQ: `bus_req_valid`=1 with the latched fields held stable until `bus_req_ready`, then go to RESP.
- RESP: wait for `bus_resp_valid`. On the completion cycle, go to REQ if a new request is accepted; otherwise go to IDLE.
- ERR: one cycle, then IDLE.
- Store format:
  - B: wdata[7:0] ×4, mask = 1<<addr[1:0].
  - H: wdata[15:0] ×2, mask 0011 if addr[1]=0, else 1100.
  - W: data unchanged, mask 1111.
- Loads: mask 0000, `bus_req_wen`=0.
- Load format: shift `bus_resp_data` right by 8×offset. B/H sign-extend; BU/HU zero-extend; W passes unchanged.
- `load_data_WB`: formatted response on the load completion cycle; otherwise a registered copy of the last completed load.
- Timeout: counter cleared on entry to REQ and incremented each REQ/RESP cycle. At `TIMEOUT_CYCLES` the bridge completes with error, drops `bus_req_valid`, and ignores any late response while in IDLE.

## Timing
- Reset values: state IDLE, `bus_req_valid`=0, `dmem_wait`=0, `dmem_badmem_e`=0, `load_data_WB`=0, timeout counter 0.
- Reset mid-transaction: state returns to IDLE next cycle and `bus_req_valid` drops. The bus is reset in the same cycle; `bus_resp_valid` is ignored in IDLE.
- Request sampled at the end of DX cycle N. `bus_req_valid` is asserted from cycle N+1 (WB).
- `dmem_wait` = (REQ) or (RESP and not `bus_resp_valid`). It deasserts combinationally in the completion cycle.
- Minimum latency, with ready=1 at N+1 and response at N+2: `dmem_wait` is high for cycle N+1 only, and WB completes in N+2.
- The response must arrive at least one cycle after acceptance. A response in the acceptance cycle is ignored.
- `dmem_badmem_e` = (ERR) or (RESP and `bus_resp_valid` and `bus_resp_err`) or (timeout). It is never asserted together with `dmem_wait`.
- Back-to-back requests: a request accepted in the completion cycle drives `bus_req_valid` in the next cycle with no idle gap.

## Test plan
- LW at 0x100, ready=1, resp 0xDEADBEEF one cycle later → wait high 1 cycle; `load_data_WB`=0xDEADBEEF; `bus_req_addr`=0x100, mask 0000.
- LB at 0x103 and LBU at 0x103, resp 0x80FF_0000 → 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x102, wdata 0x1234ABCD → wdata 0xABCDABCD, mask 1100, `wen`=1; `load_data_WB` unchanged.
- LW at 0x101 → no `bus_req_valid`; `badmem_e`=1 for exactly one cycle after DX; `wait`=0 throughout.
- `bus_req_ready` low 3 cycles, then resp with err=1 → wait high 4+ cycles; `badmem_e`=1 in the response cycle; a new `dmem_en` in that cycle is ignored.
- `TIMEOUT_CYCLES`=4, no response → `badmem_e` after 4 wait cycles; a late resp in IDLE is ignored. Reset asserted in RESP → IDLE and `bus_req_valid`=0 next cycle.
